sysid_check_ctrl: RTL and testbench

SYSID_CHECK_CTRL -- requirements
Module: sysid_check_ctrl

---
 rtl/sysid_check_ctrl_pkg.sv | 19 +
 rtl/sysid_check_ctrl_if.sv | 24 ++
 rtl/sysid_check_ctrl_timer.sv | 30 +++
 rtl/sysid_check_ctrl.sv | 135 +++++++++++++
 tb/tb_sysid_check_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sysid_check_ctrl_pkg.sv
// Shared types and constants for the system-ID check controller.
package sysid_ctrl_pkg;

  localparam int DATA_W = 32;

  localparam logic ID_ADDR = 1'b0;
  localparam logic TS_ADDR = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd2;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1498619909;

  typedef enum logic [1:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CMP
  } state_t;

endpackage

// File: rtl/sysid_check_ctrl_if.sv
// Avalon-MM read-only link between the check controller and the system-ID slave.
interface sysid_check_ctrl_if;
  import sysid_ctrl_pkg::*;

  logic              avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );

endinterface

// File: rtl/sysid_check_ctrl_timer.sv
// Counts consecutive waitrequest cycles of one read and flags the cycle that exhausts the budget.
module sysid_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // A cycle without a stall ends the read, so dropping count_en doubles as the clear on state entry.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!count_en) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = count_en && (count == LAST);

endmodule

// File: rtl/sysid_check_ctrl.sv
// Reads system-ID words 0 and 1 over Avalon-MM and compares them against the expected build identity.
module sysid_check_ctrl
  import sysid_ctrl_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  sysid_check_ctrl_if.master avm,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               id_ok,
  output logic               ts_ok,
  output logic               timeout,
  output logic [31:0]        id_value,
  output logic [31:0]        ts_value
);

  state_t      state, state_n;
  logic        read_q, read_n;
  logic        addr_q, addr_n;
  logic        busy_n, done_n, pass_n, id_ok_n, ts_ok_n, timeout_n;
  logic [31:0] id_value_n, ts_value_n;
  logic        auto_pending;
  logic        waiting, expired;

  assign waiting = ((state == RD_ID) || (state == RD_TS)) && avm.avm_waitrequest;

  sysid_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .count_en(waiting),
    .expired (expired)
  );

  // Bus strobes are computed for the next state so they leave the register together with it.
  always_comb begin
    state_n    = state;
    read_n     = 1'b0;
    addr_n     = ID_ADDR;
    done_n     = 1'b0;
    pass_n     = pass;
    id_ok_n    = id_ok;
    ts_ok_n    = ts_ok;
    timeout_n  = timeout;
    id_value_n = id_value;
    ts_value_n = ts_value;

    unique case (state)
      IDLE: begin
        if (start || auto_pending) begin
          state_n = RD_ID;
          read_n  = 1'b1;
          addr_n  = ID_ADDR;
        end
      end
      RD_ID, RD_TS: begin
        read_n = 1'b1;
        addr_n = (state == RD_TS) ? TS_ADDR : ID_ADDR;
        if (!avm.avm_waitrequest) begin
          if (state == RD_ID) begin
            id_value_n = avm.avm_readdata;
            state_n    = RD_TS;
            addr_n     = TS_ADDR;
          end else begin
            ts_value_n = avm.avm_readdata;
            state_n    = CMP;
            read_n     = 1'b0;
            addr_n     = ID_ADDR;
          end
        end else if (expired) begin
          state_n   = IDLE;
          read_n    = 1'b0;
          addr_n    = ID_ADDR;
          done_n    = 1'b1;
          timeout_n = 1'b1;
          pass_n    = 1'b0;
          id_ok_n   = 1'b0;
          ts_ok_n   = 1'b0;
        end
      end
      CMP: begin
        id_ok_n   = (id_value == EXPECTED_ID);
        ts_ok_n   = (ts_value == EXPECTED_TS);
        timeout_n = 1'b0;
        pass_n    = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
        done_n    = 1'b1;
        state_n   = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state        <= IDLE;
      read_q       <= 1'b0;
      addr_q       <= ID_ADDR;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      id_ok        <= 1'b0;
      ts_ok        <= 1'b0;
      timeout      <= 1'b0;
      id_value     <= '0;
      ts_value     <= '0;
      auto_pending <= AUTO_START;
    end else begin
      state        <= state_n;
      read_q       <= read_n;
      addr_q       <= addr_n;
      busy         <= busy_n;
      done         <= done_n;
      pass         <= pass_n;
      id_ok        <= id_ok_n;
      ts_ok        <= ts_ok_n;
      timeout      <= timeout_n;
      id_value     <= id_value_n;
      ts_value     <= ts_value_n;
      auto_pending <= 1'b0;
    end
  end

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;

endmodule

// File: tb/tb_sysid_check_ctrl.sv
// Self-checking bench for sysid_check_ctrl: vector table, hand sequences and randomized checks.
`timescale 1ns/1ps
module tb_sysid_check_ctrl;

  localparam int          TMO    = 16;
  localparam logic [31:0] EXP_ID = 32'd2;
  localparam logic [31:0] EXP_TS = 32'd1498619909;
  localparam int          BUDGET = 120;

  typedef struct {
    logic [31:0] id_word;
    logic [31:0] ts_word;
    int          id_waits;
    int          ts_waits;
    logic        exp_pass;
    logic        exp_id_ok;
    logic        exp_ts_ok;
    logic        exp_timeout;
    logic [31:0] exp_id_value;
    logic [31:0] exp_ts_value;
    int          exp_latency;
  } vec_t;

  typedef struct {
    logic        pass;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout;
    logic [31:0] id_value;
    logic [31:0] ts_value;
    int          latency;
    int          id_cycles;
    int          ts_cycles;
    int          addr_glitches;
  } obs_t;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        start   = 1'b0;
  logic [31:0] id_word = EXP_ID;
  logic [31:0] ts_word = EXP_TS;
  int          id_waits = 0;
  int          ts_waits = 0;
  int          wcnt     = 0;
  int          checks   = 0;
  int          errors   = 0;
  logic [31:0] prev_id  = '0;
  logic [31:0] prev_ts  = '0;

  logic        busy, done, pass, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;
  logic        a_busy, a_done, a_pass, a_id_ok, a_ts_ok, a_timeout;
  logic [31:0] a_id_value, a_ts_value;

  sysid_check_ctrl_if bus ();
  sysid_check_ctrl_if abus ();

  sysid_check_ctrl #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .avm(bus.master),
    .busy(busy), .done(done), .pass(pass), .id_ok(id_ok), .ts_ok(ts_ok),
    .timeout(timeout), .id_value(id_value), .ts_value(ts_value)
  );

  sysid_check_ctrl #(
    .AUTO_START(1'b1)
  ) dut_auto (
    .clock(clock), .reset_n(reset_n), .start(1'b0), .avm(abus.master),
    .busy(a_busy), .done(a_done), .pass(a_pass), .id_ok(a_id_ok), .ts_ok(a_ts_ok),
    .timeout(a_timeout), .id_value(a_id_value), .ts_value(a_ts_value)
  );

  always #5 clock = ~clock;

  // Slave stalls each read for a programmed number of cycles and returns junk while stalling.
  assign bus.avm_waitrequest = bus.avm_read && (wcnt < (bus.avm_address ? ts_waits : id_waits));
  assign bus.avm_readdata    = bus.avm_waitrequest ? 32'hDEAD_BEEF
                                                   : (bus.avm_address ? ts_word : id_word);
  always @(posedge clock) wcnt <= (bus.avm_read && bus.avm_waitrequest) ? wcnt + 1 : 0;

  assign abus.avm_waitrequest = 1'b0;
  assign abus.avm_readdata    = abus.avm_address ? EXP_TS : EXP_ID;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Transaction-level reference: outcome decided by which read (if any) exceeds the stall budget.
  function automatic vec_t model(input logic [31:0] idw, input logic [31:0] tsw,
                                 input int idwt, input int tswt,
                                 input logic [31:0] pid, input logic [31:0] pts);
    vec_t r;
    r = '{idw, tsw, idwt, tswt, 1'b0, 1'b0, 1'b0, 1'b0, pid, pts, 0};
    if (idwt >= TMO) begin
      r.exp_timeout = 1'b1;
      r.exp_latency = TMO + 1;
    end else if (tswt >= TMO) begin
      r.exp_timeout  = 1'b1;
      r.exp_id_value = idw;
      r.exp_latency  = idwt + 2 + TMO;
    end else begin
      r.exp_id_ok    = (idw == EXP_ID);
      r.exp_ts_ok    = (tsw == EXP_TS);
      r.exp_pass     = (idw == EXP_ID) && (tsw == EXP_TS);
      r.exp_id_value = idw;
      r.exp_ts_value = tsw;
      r.exp_latency  = idwt + tswt + 4;
    end
    return r;
  endfunction

  task automatic wait_done(input bit use_auto, input int first_cyc, output int lat);
    lat = -1;
    for (int c = first_cyc; c <= BUDGET; c++) begin
      if ((use_auto ? a_done : done) === 1'b1) begin
        lat = c;
        break;
      end
      @(negedge clock);
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_wait: got no done within %0d cycles, expected a done pulse", BUDGET);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] idw, input logic [31:0] tsw,
                                input int idwt, input int tswt, output obs_t o);
    bit   prev_stall;
    logic prev_addr;
    o = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, -1, 0, 0, 0};
    id_word  = idw;
    ts_word  = tsw;
    id_waits = idwt;
    ts_waits = tswt;
    start    = 1'b1;
    @(negedge clock);
    start      = 1'b0;
    prev_stall = 1'b0;
    prev_addr  = 1'b0;
    for (int c = 1; c <= BUDGET; c++) begin
      if (prev_stall && bus.avm_read && (bus.avm_address !== prev_addr)) o.addr_glitches++;
      if (bus.avm_read === 1'b1) begin
        if (bus.avm_address) o.ts_cycles++;
        else                 o.id_cycles++;
      end
      if (done === 1'b1) begin
        o.latency  = c;
        o.pass     = pass;
        o.id_ok    = id_ok;
        o.ts_ok    = ts_ok;
        o.timeout  = timeout;
        o.id_value = id_value;
        o.ts_value = ts_value;
        break;
      end
      prev_stall = bus.avm_read && bus.avm_waitrequest;
      prev_addr  = bus.avm_address;
      @(negedge clock);
    end
    if (o.latency < 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL txn_wait: got no done within %0d cycles, expected a done pulse", BUDGET);
    end
  endtask

  task automatic check_output(input string tag, input obs_t o, input vec_t e);
    int idc, tsc;
    idc = (e.id_waits >= TMO) ? TMO : e.id_waits + 1;
    tsc = (e.id_waits >= TMO) ? 0 : ((e.ts_waits >= TMO) ? TMO : e.ts_waits + 1);
    check_bit($sformatf("%s.pass", tag), o.pass, e.exp_pass);
    check_bit($sformatf("%s.id_ok", tag), o.id_ok, e.exp_id_ok);
    check_bit($sformatf("%s.ts_ok", tag), o.ts_ok, e.exp_ts_ok);
    check_bit($sformatf("%s.timeout", tag), o.timeout, e.exp_timeout);
    check_val($sformatf("%s.id_value", tag), o.id_value, e.exp_id_value);
    check_val($sformatf("%s.ts_value", tag), o.ts_value, e.exp_ts_value);
    check_val($sformatf("%s.latency", tag), o.latency, e.exp_latency);
    check_val($sformatf("%s.id_read_cycles", tag), idc, o.id_cycles);
    check_val($sformatf("%s.ts_read_cycles", tag), tsc, o.ts_cycles);
    check_val($sformatf("%s.addr_stable", tag), o.addr_glitches, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion before 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t tbl [8];
    vec_t e;
    obs_t o;
    int   lat;
    bit   seen;

    // {id_word, ts_word, id_waits, ts_waits, pass, id_ok, ts_ok, timeout, id_value, ts_value, latency}
    tbl[0] = '{EXP_ID, EXP_TS,        0,  0,    1'b1, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS,        4};
    tbl[1] = '{32'd3,  EXP_TS,        0,  0,    1'b0, 1'b0, 1'b1, 1'b0, 32'd3,  EXP_TS,        4};
    tbl[2] = '{EXP_ID, EXP_TS,        3,  0,    1'b1, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS,        7};
    tbl[3] = '{EXP_ID, 32'h1234_5678, 0,  2,    1'b0, 1'b1, 1'b0, 1'b0, EXP_ID, 32'h1234_5678, 6};
    tbl[4] = '{EXP_ID, EXP_TS,        0,  1000, 1'b0, 1'b0, 1'b0, 1'b1, EXP_ID, 32'h1234_5678, 18};
    tbl[5] = '{32'd7,  EXP_TS,        16, 0,    1'b0, 1'b0, 1'b0, 1'b1, EXP_ID, 32'h1234_5678, 17};
    tbl[6] = '{32'd7,  32'd9,         15, 15,   1'b0, 1'b0, 1'b0, 1'b0, 32'd7,  32'd9,         34};
    tbl[7] = '{EXP_ID, EXP_TS,        15, 0,    1'b1, 1'b1, 1'b1, 1'b0, EXP_ID, EXP_TS,        19};

    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_bit("rst.read", bus.avm_read, 1'b0);
    check_bit("rst.address", bus.avm_address, 1'b0);
    check_bit("rst.busy", busy, 1'b0);
    check_bit("rst.done", done, 1'b0);
    check_bit("rst.pass", pass, 1'b0);
    check_bit("rst.flags", id_ok | ts_ok | timeout, 1'b0);
    check_val("rst.id_value", id_value, 32'h0);
    check_val("rst.ts_value", ts_value, 32'h0);
    check_bit("rst.auto_read", abus.avm_read, 1'b0);

    reset_n = 1'b1;
    @(negedge clock);
    check_bit("auto.read", abus.avm_read, 1'b1);
    check_bit("auto.address", abus.avm_address, 1'b0);
    check_bit("auto.busy", a_busy, 1'b1);
    check_bit("auto.no_autostart_main", busy, 1'b0);
    wait_done(1'b1, 1, lat);
    check_val("auto.latency", lat, 4);
    check_bit("auto.pass", a_pass, 1'b1);

    @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(tbl[i].id_word, tbl[i].ts_word, tbl[i].id_waits, tbl[i].ts_waits, o);
      check_output($sformatf("vec%0d", i), o, tbl[i]);
      @(negedge clock);
      check_bit($sformatf("vec%0d.done_pulse", i), done, 1'b0);
      prev_id = tbl[i].exp_id_value;
      prev_ts = tbl[i].exp_ts_value;
    end

    // Start raised in the done cycle must launch a new check without disturbing held results.
    e = model(EXP_ID, 32'd5, 0, 0, prev_id, prev_ts);
    apply_stimulus(EXP_ID, 32'd5, 0, 0, o);
    check_output("chain", o, e);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_bit("chain.busy", busy, 1'b1);
    check_bit("chain.read", bus.avm_read, 1'b1);
    check_bit("chain.ts_ok_held", ts_ok, 1'b0);
    check_val("chain.ts_value_held", ts_value, 32'd5);
    wait_done(1'b0, 1, lat);
    check_val("chain.latency", lat, 4);
    prev_id = EXP_ID;
    prev_ts = 32'd5;

    @(negedge clock);
    id_word  = EXP_ID;
    ts_word  = EXP_TS;
    id_waits = 5;
    ts_waits = 0;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(1'b0, 3, lat);
    check_val("ignored.latency", lat, 9);
    check_bit("ignored.pass", pass, 1'b1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (busy || bus.avm_read || done) seen = 1'b1;
    end
    check_bit("ignored.not_queued", seen, 1'b0);
    prev_id = EXP_ID;
    prev_ts = EXP_TS;

    for (int i = 0; i < 30; i++) begin
      logic [31:0] idw, tsw;
      int          iw, tw, r;
      idw = ($urandom_range(0, 1) == 0) ? EXP_ID : $urandom;
      tsw = ($urandom_range(0, 1) == 0) ? EXP_TS : $urandom;
      r   = $urandom_range(0, 9);
      iw  = (r < 6) ? $urandom_range(0, 3) : ((r < 9) ? $urandom_range(14, 17) : 40);
      r   = $urandom_range(0, 9);
      tw  = (r < 6) ? $urandom_range(0, 3) : ((r < 9) ? $urandom_range(14, 17) : 40);
      e   = model(idw, tsw, iw, tw, prev_id, prev_ts);
      apply_stimulus(idw, tsw, iw, tw, o);
      check_output($sformatf("rnd%0d", i), o, e);
      prev_id = e.exp_id_value;
      prev_ts = e.exp_ts_value;
      @(negedge clock);
    end

    // Abort in the middle of the timestamp read.
    id_word  = EXP_ID;
    ts_word  = EXP_TS;
    id_waits = 0;
    ts_waits = 1000;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < BUDGET; c++) begin
      if (bus.avm_read && bus.avm_address) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check_bit("abort.reached_ts", seen, 1'b1);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    check_bit("abort.read", bus.avm_read, 1'b0);
    check_bit("abort.busy", busy, 1'b0);
    check_bit("abort.done", done, 1'b0);
    check_bit("abort.flags", pass | id_ok | ts_ok | timeout, 1'b0);
    check_val("abort.id_value", id_value, 32'h0);
    check_val("abort.ts_value", ts_value, 32'h0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (done || bus.avm_read) seen = 1'b1;
    end
    check_bit("abort.quiet", seen, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
